// File: rtl/uart_txd_if.sv
// UART transmit bus interface: parity-tagged byte FIFO feeding the TX serializer.
// First-word fall-through head register, registered level, sticky error bits.
module uart_txd_if #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wr,
   input  logic [31:0]   i_wdata,
   output logic          o_wfull,
   output logic          o_busy,
   output logic [1:0]    o_error,
   input  logic          i_error_clr,
   input  logic          i_parity_en,
   input  logic          i_parity_odd,
   input  logic          i_txd_fifo_rd,
   output logic [9:0]    o_txd_fifo_rdata,
   output logic          o_txd_fifo_rempty,
   input  logic          i_txd_busy,
   output logic [AW:0]   o_level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [9:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   level_q, level_d;
   logic [1:0]    err_q, err_d;
   logic [9:0]    rdata_q, rdata_d;

   logic          full, empty;
   logic          pop, wr_acc, ovf, unf, par;
   logic [9:0]    went;
   logic          unused_w;

   assign unused_w = ^i_wdata[31:8];

   assign full  = (level_q == FULL_LVL);
   assign empty = (level_q == '0);

   always_comb begin
      pop     = i_txd_fifo_rd & ~empty;
      wr_acc  = i_wr & (~full | pop);
      ovf     = i_wr & full & ~pop;
      unf     = i_txd_fifo_rd & empty;
      par     = i_parity_en & ((^i_wdata[7:0]) ^ i_parity_odd);
      went    = {i_parity_en, par, i_wdata[7:0]};
      wptr_d  = wr_acc ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
      level_d = level_q + (AW+1)'(wr_acc) - (AW+1)'(pop);
      err_d   = (err_q & ~{2{i_error_clr}}) | {unf, ovf};
      rdata_d = rdata_q;
      // New head is the incoming byte when it lands at the read pointer
      if (level_d != '0) begin
         if (wr_acc && (wptr_q == rptr_d))
            rdata_d = went;
         else
            rdata_d = mem_q[rptr_d];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         err_q   <= 2'b00;
         rdata_q <= 10'h000;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && wr_acc)
         mem_q[wptr_q] <= went;
   end

   assign o_wfull           = full;
   assign o_txd_fifo_rempty = empty;
   assign o_level           = level_q;
   assign o_error           = err_q;
   assign o_txd_fifo_rdata  = rdata_q;
   assign o_busy            = ~empty | i_txd_busy;

endmodule

// File: tb/tb_uart_txd_if.sv
// Directed testbench for uart_txd_if: FIFO order, parity tagging,
// full/empty boundaries, sticky errors and mid-operation reset.
module tb_uart_txd_if;

   logic        clk = 1'b0;
   logic        rst, wr, eclr, pen, podd, rd, txbusy;
   logic [31:0] wdata;
   logic        wfull, busy, rempty;
   logic [1:0]  err;
   logic [9:0]  rdata;
   logic [4:0]  level;

   int n_chk  = 0;
   int n_pass = 0;

   uart_txd_if #(.DEPTH(16)) dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_wr              (wr),
      .i_wdata           (wdata),
      .o_wfull           (wfull),
      .o_busy            (busy),
      .o_error           (err),
      .i_error_clr       (eclr),
      .i_parity_en       (pen),
      .i_parity_odd      (podd),
      .i_txd_fifo_rd     (rd),
      .o_txd_fifo_rdata  (rdata),
      .o_txd_fifo_rempty (rempty),
      .i_txd_busy        (txbusy),
      .o_level           (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wr = 1'b0; eclr = 1'b0; pen = 1'b0; podd = 1'b0;
      rd = 1'b0; txbusy = 1'b0; wdata = '0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_level",  32'(level), 0);
      chk("rst_rempty", 32'(rempty), 1);
      chk("rst_wfull",  32'(wfull), 0);
      chk("rst_err",    32'(err), 0);
      chk("rst_rdata",  32'(rdata), 0);
      chk("rst_busy",   32'(busy), 0);

      // even parity on 0x93
      wr = 1'b1; wdata = 32'h93; pen = 1'b1; podd = 1'b0;
      step();
      wr = 1'b0;
      chk("w1_rempty", 32'(rempty), 0);
      chk("w1_level",  32'(level), 1);
      chk("w1_rdata",  32'(rdata), 32'h293);
      chk("w1_busy",   32'(busy), 1);
      rd = 1'b1; step(); rd = 1'b0;
      chk("w1_popped", 32'(rempty), 1);

      // odd parity, then parity disabled
      wr = 1'b1; wdata = 32'h93; pen = 1'b1; podd = 1'b1;
      step();
      pen = 1'b0; podd = 1'b0;
      step();
      wr = 1'b0;
      chk("p_level", 32'(level), 2);
      chk("p_head0", 32'(rdata), 32'h393);
      rd = 1'b1; step();
      chk("p_head1", 32'(rdata), 32'h093);
      step(); rd = 1'b0;
      chk("p_rempty", 32'(rempty), 1);
      chk("p_level0", 32'(level), 0);

      // fill to full
      for (int i = 0; i < 16; i++) begin
         wr = 1'b1; wdata = 32'(i);
         step();
      end
      wr = 1'b0;
      chk("f_wfull", 32'(wfull), 1);
      chk("f_level", 32'(level), 16);
      wr = 1'b1; wdata = 32'hAA; step(); wr = 1'b0;
      chk("ovf_err",   32'(err), 32'h1);
      chk("ovf_level", 32'(level), 16);
      eclr = 1'b1; step(); eclr = 1'b0;
      chk("clr_err", 32'(err), 0);
      chk("f_head",  32'(rdata), 32'h000);

      // write and pop together while full
      wr = 1'b1; wdata = 32'h55; rd = 1'b1; step();
      wr = 1'b0; rd = 1'b0;
      chk("fp_err",   32'(err), 0);
      chk("fp_level", 32'(level), 16);
      for (int i = 1; i < 17; i++) begin
         chk($sformatf("drain%0d", i), 32'(rdata),
             (i == 16) ? 32'h055 : 32'(i));
         rd = 1'b1; step(); rd = 1'b0;
      end
      chk("d_rempty", 32'(rempty), 1);
      chk("d_err",    32'(err), 0);

      // pop while empty with a write
      wr = 1'b1; wdata = 32'h3C; rd = 1'b1; step();
      wr = 1'b0; rd = 1'b0;
      chk("unf_err",   32'(err), 32'h2);
      chk("unf_level", 32'(level), 1);
      chk("unf_rdata", 32'(rdata), 32'h03C);
      rd = 1'b1; step();
      chk("unf_pop", 32'(level), 0);

      // clear racing a new underflow: set wins
      eclr = 1'b1; step();
      rd = 1'b0;
      chk("race_err", 32'(err), 32'h2);
      step(); eclr = 1'b0;
      chk("clr2_err", 32'(err), 0);

      // reset mid-fill with write and pop asserted
      for (int i = 0; i < 5; i++) begin
         wr = 1'b1; wdata = 32'hE0 + 32'(i);
         step();
      end
      wr = 1'b0;
      chk("mf_level", 32'(level), 5);
      txbusy = 1'b1;
      rst = 1'b1; wr = 1'b1; rd = 1'b1; step();
      rst = 1'b0; wr = 1'b0; rd = 1'b0;
      chk("mr_level",  32'(level), 0);
      chk("mr_rempty", 32'(rempty), 1);
      chk("mr_err",    32'(err), 0);
      chk("mr_busy1",  32'(busy), 1);
      txbusy = 1'b0; #1;
      chk("mr_busy0",  32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
